// File: rtl/tetris_dp_param_if.sv
// Command bus between the tetris game controller and the playfield datapath.
//   cmd_valid  : controller has a command this cycle
//   cmd_ready  : datapath can take a command (IDLE/ACTIVE)
//   cmd_op     : 1 SPAWN, 2 LEFT, 3 RIGHT, 4 ROT, 5 DROP (0,6,7 rejected)
//   cmd_piece  : piece type used by SPAWN
// master = controller side, slave = datapath side.
interface tetris_dp_param_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_piece;

  modport master (output cmd_valid, output cmd_op, output cmd_piece, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_piece, output cmd_ready);
endinterface

// File: rtl/tetris_dp_param.sv
// Parametrised tetris playfield datapath: W x H board of locked cells plus one
// falling 2x2-boxed piece. One command per cycle, collision checking, locking,
// and sequential row clearing (one row examined or collapsed per cycle).
// Ports:
//   clka           rising-edge clock
//   restart_n      asynchronous active-low reset
//   cmd            command bus (slave side): valid/ready/op/piece
//   board_out      locked cells, bit r*W+c = (row r, col c), row 0 at top
//   piece_valid    a falling piece exists
//   loc_col/row    piece box position
//   rotation_out   piece rotation
//   curr_piece_out piece type
//   touched        one-cycle pulse when a piece locks
//   error_out      one-cycle pulse on a rejected command or blocked spawn
//   game_over      level, set once the board overflows
//   lines_total    saturating count of cleared rows
// All outputs are registered.
module tetris_dp_param #(
  parameter int W         = 4,
  parameter int H         = 8,
  parameter int SPAWN_COL = 1,
  parameter int LW        = 8,
  localparam int CW       = (W > 1) ? $clog2(W) : 1,
  localparam int RW       = (H > 1) ? $clog2(H) : 1
) (
  input  logic                 clka,
  input  logic                 restart_n,
  tetris_dp_param_if.slave     cmd,
  output logic [W*H-1:0]       board_out,
  output logic                 piece_valid,
  output logic [CW-1:0]        loc_col,
  output logic [RW-1:0]        loc_row,
  output logic [1:0]           rotation_out,
  output logic [1:0]           curr_piece_out,
  output logic                 touched,
  output logic                 error_out,
  output logic                 game_over,
  output logic [LW-1:0]        lines_total
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [2:0] OP_SPAWN = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_ROT   = 3'd4;
  localparam logic [2:0] OP_DROP  = 3'd5;

  localparam logic [W*H-1:0] ONE_CELL = {{(W*H-1){1'b0}}, 1'b1};

  // 2x2 occupancy mask: b0=(r,c) b1=(r,c+1) b2=(r+1,c) b3=(r+1,c+1)
  function automatic logic [3:0] piece_mask(input logic [1:0] ptype, input logic [1:0] rot);
    logic [3:0] m;
    case (ptype)
      2'd0: m = 4'b0001;
      2'd1: m = rot[0] ? 4'b0101 : 4'b0011;
      2'd2: begin
        case (rot)
          2'd0:    m = 4'b0111;
          2'd1:    m = 4'b1011;
          2'd2:    m = 4'b1110;
          default: m = 4'b1101;
        endcase
      end
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True if any mask cell leaves the board or lands on a locked cell.
  // row/col are signed so a left move from column 0 is caught as well.
  function automatic logic collides(input logic [W*H-1:0] board, input int row,
                                    input int col, input logic [3:0] mask);
    logic hit;
    int   r;
    int   c;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = row + i / 2;
      c = col + i % 2;
      if (!mask[i[1:0]]) hit = hit;
      else if (r < 0 || r >= H || c < 0 || c >= W) hit = 1'b1;
      else if ((board & (ONE_CELL << (r * W + c))) != '0) hit = 1'b1;
      else hit = hit;
    end
    return hit;
  endfunction

  // Board bits covered by the piece (only called for a collision-free placement).
  function automatic logic [W*H-1:0] piece_cells(input int row, input int col, input logic [3:0] mask);
    logic [W*H-1:0] cells;
    int             r;
    int             c;
    cells = '0;
    for (int i = 0; i < 4; i++) begin
      r = row + i / 2;
      c = col + i % 2;
      if (mask[i[1:0]] && r < H && c < W) cells = cells | (ONE_CELL << (r * W + c));
      else cells = cells;
    end
    return cells;
  endfunction

  // Remove row `scan`: rows 1..scan take the row above, row 0 becomes empty.
  function automatic logic [W*H-1:0] collapse_row(input logic [W*H-1:0] b, input int scan);
    logic [W*H-1:0] nb;
    nb = b;
    nb[W-1:0] = '0;
    for (int r = 1; r < H; r++) begin
      if (r <= scan) nb[r*W +: W] = b[(r-1)*W +: W];
      else nb[r*W +: W] = b[r*W +: W];
    end
    return nb;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [W*H-1:0] board_q, board_d;
  logic [RW-1:0]  scan_q, scan_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic [1:0]     rot_q, rot_d;
  logic [1:0]     type_q, type_d;
  logic           pv_q, pv_d;
  logic           touched_q, touched_d;
  logic           error_q, error_d;
  logic           over_q, over_d;
  logic           ready_q, ready_d;
  logic [LW-1:0]  lines_q, lines_d;

  logic           accept_s;
  logic [3:0]     mask_cur_s;
  logic [W-1:0]   scan_row_s;

  // Next-state logic: command execution, locking and row clearing.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    scan_d     = scan_q;
    row_d      = row_q;
    col_d      = col_q;
    rot_d      = rot_q;
    type_d     = type_q;
    pv_d       = pv_q;
    touched_d  = 1'b0;
    error_d    = 1'b0;
    over_d     = over_q;
    lines_d    = lines_q;
    accept_s   = cmd.cmd_valid & ready_q;
    mask_cur_s = piece_mask(type_q, rot_q);
    scan_row_s = W'(board_q >> (int'(scan_q) * W));

    case (state_q)
      ST_IDLE: begin
        if (accept_s && cmd.cmd_op == OP_SPAWN) begin
          row_d  = '0;
          col_d  = CW'(SPAWN_COL);
          rot_d  = 2'd0;
          type_d = cmd.cmd_piece;
          if (collides(board_q, 0, SPAWN_COL, piece_mask(cmd.cmd_piece, 2'd0))) begin
            state_d = ST_OVER;
            error_d = 1'b1;
            over_d  = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
            pv_d    = 1'b1;
          end
        end else if (accept_s) begin
          error_d = 1'b1;
        end else begin
          error_d = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            OP_LEFT: begin
              if (collides(board_q, int'(row_q), int'(col_q) - 1, mask_cur_s)) error_d = 1'b1;
              else col_d = col_q - 1'b1;
            end
            OP_RIGHT: begin
              if (collides(board_q, int'(row_q), int'(col_q) + 1, mask_cur_s)) error_d = 1'b1;
              else col_d = col_q + 1'b1;
            end
            OP_ROT: begin
              if (collides(board_q, int'(row_q), int'(col_q), piece_mask(type_q, rot_q + 2'd1))) error_d = 1'b1;
              else rot_d = rot_q + 2'd1;
            end
            OP_DROP: begin
              if (!collides(board_q, int'(row_q) + 1, int'(col_q), mask_cur_s)) begin
                row_d = row_q + 1'b1;
              end else begin
                // Piece rests here: merge it into the board and start the scan at the bottom row.
                board_d   = board_q | piece_cells(int'(row_q), int'(col_q), mask_cur_s);
                touched_d = 1'b1;
                pv_d      = 1'b0;
                state_d   = ST_CLEAR;
                scan_d    = RW'(H - 1);
              end
            end
            default: error_d = 1'b1;
          endcase
        end else begin
          error_d = 1'b0;
        end
      end

      ST_CLEAR: begin
        // A collapsed row pulls a new row into `scan`, so the same row is re-examined.
        if (&scan_row_s) begin
          board_d = collapse_row(board_q, int'(scan_q));
          if (lines_q != {LW{1'b1}}) lines_d = lines_q + 1'b1;
          else lines_d = lines_q;
        end else if (scan_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          scan_d = scan_q - 1'b1;
        end
      end

      ST_OVER: begin
        over_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
  end

  // State and output registers.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q   <= ST_IDLE;
      board_q   <= '0;
      scan_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rot_q     <= 2'd0;
      type_q    <= 2'd0;
      pv_q      <= 1'b0;
      touched_q <= 1'b0;
      error_q   <= 1'b0;
      over_q    <= 1'b0;
      ready_q   <= 1'b0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      scan_q    <= scan_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rot_q     <= rot_d;
      type_q    <= type_d;
      pv_q      <= pv_d;
      touched_q <= touched_d;
      error_q   <= error_d;
      over_q    <= over_d;
      ready_q   <= ready_d;
      lines_q   <= lines_d;
    end
  end

  assign cmd.cmd_ready  = ready_q;
  assign board_out      = board_q;
  assign piece_valid    = pv_q;
  assign loc_col        = col_q;
  assign loc_row        = row_q;
  assign rotation_out   = rot_q;
  assign curr_piece_out = type_q;
  assign touched        = touched_q;
  assign error_out      = error_q;
  assign game_over      = over_q;
  assign lines_total    = lines_q;

endmodule

// File: tb/tb_tetris_dp_param.sv
// Directed bench for tetris_dp_param (W=4, H=8, SPAWN_COL=1, LW=8).
module tb_tetris_dp_param;
  localparam int W  = 4;
  localparam int H  = 8;
  localparam int LW = 8;

  localparam logic [2:0] SPAWN = 3'd1;
  localparam logic [2:0] LEFT  = 3'd2;
  localparam logic [2:0] RIGHT = 3'd3;
  localparam logic [2:0] ROT   = 3'd4;
  localparam logic [2:0] DROP  = 3'd5;

  logic           clka = 1'b0;
  logic           restart_n = 1'b0;
  logic [W*H-1:0] board_out;
  logic           piece_valid;
  logic [1:0]     loc_col;
  logic [2:0]     loc_row;
  logic [1:0]     rotation_out;
  logic [1:0]     curr_piece_out;
  logic           touched;
  logic           error_out;
  logic           game_over;
  logic [LW-1:0]  lines_total;

  tetris_dp_param_if ifc ();

  tetris_dp_param #(.W(W), .H(H), .SPAWN_COL(1), .LW(LW)) dut (
    .clka           (clka),
    .restart_n      (restart_n),
    .cmd            (ifc),
    .board_out      (board_out),
    .piece_valid    (piece_valid),
    .loc_col        (loc_col),
    .loc_row        (loc_row),
    .rotation_out   (rotation_out),
    .curr_piece_out (curr_piece_out),
    .touched        (touched),
    .error_out      (error_out),
    .game_over      (game_over),
    .lines_total    (lines_total)
  );

  always #5 clka = ~clka;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic [2:0] op;
    logic [1:0] piece;
    logic       err;
    logic       tch;
    logic       pv;
    logic [1:0] col;
    logic [2:0] row;
    logic [1:0] rot;
    logic [1:0] typ;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [1:0] pc,
                              input logic err, input logic tch, input logic pv,
                              input logic [1:0] col, input logic [2:0] row,
                              input logic [1:0] rot, input logic [1:0] typ);
    vec_t x;
    x.valid = v;  x.op = op;   x.piece = pc;
    x.err = err;  x.tch = tch; x.pv = pv;
    x.col = col;  x.row = row; x.rot = rot; x.typ = typ;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    restart_n = 1'b0;
    ifc.cmd_valid = 1'b0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    restart_n = 1'b1;
    @(posedge clka);
    #1;
  endtask

  // Present one command for one edge, then sample #1 after that edge.
  task automatic do_cmd(input logic [2:0] op, input logic [1:0] pc, input logic v = 1'b1);
    @(negedge clka);
    ifc.cmd_valid = v;
    ifc.cmd_op    = op;
    ifc.cmd_piece = pc;
    @(posedge clka);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  // Counts edges with cmd_ready low, bounded.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 64) begin
      @(posedge clka);
      #1;
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  task automatic drop_to_lock(input string name);
    int n;
    n = 0;
    do begin
      do_cmd(DROP, 2'd0);
      n++;
    end while (touched !== 1'b1 && n < 16);
    check(name, touched, 1'b1);
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    ifc.cmd_piece = 2'd0;

    // Table: starts from reset; exercises IDLE rejects, moves, bounds and a full fall of type0.
    vecs[0]  = mk(1'b1, ROT,   2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[1]  = mk(1'b1, 3'd0,  2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[2]  = mk(1'b1, SPAWN, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 2'd0, 2'd0);
    vecs[3]  = mk(1'b1, LEFT,  2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[4]  = mk(1'b1, LEFT,  2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[5]  = mk(1'b1, SPAWN, 2'd2, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[6]  = mk(1'b1, 3'd7,  2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0);
    vecs[7]  = mk(1'b1, ROT,   2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd1, 2'd0);
    vecs[8]  = mk(1'b1, RIGHT, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 2'd1, 2'd0);
    vecs[9]  = mk(1'b1, RIGHT, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 2'd1, 2'd0);
    vecs[10] = mk(1'b1, RIGHT, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 2'd1, 2'd0);
    vecs[11] = mk(1'b1, RIGHT, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 3'd0, 2'd1, 2'd0);
    vecs[12] = mk(1'b1, DROP,  2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 2'd1, 2'd0);
    vecs[13] = mk(1'b0, DROP,  2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd1, 2'd1, 2'd0);
    for (int i = 0; i < 6; i++)
      vecs[14+i] = mk(1'b1, DROP, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 3'(i + 2), 2'd1, 2'd0);
    vecs[20] = mk(1'b1, DROP,  2'd0, 1'b0, 1'b1, 1'b0, 2'd3, 3'd7, 2'd1, 2'd0);

    // Outputs while reset is held
    #2;
    check("reset_outputs",
          {board_out, piece_valid, loc_col, loc_row, rotation_out, curr_piece_out,
           touched, error_out, game_over, lines_total, ifc.cmd_ready},
          {32'h0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0});
    do_reset();
    check("ready_after_reset", ifc.cmd_ready, 1'b1);

    for (int i = 0; i < 21; i++) begin
      do_cmd(vecs[i].op, vecs[i].piece, vecs[i].valid);
      check($sformatf("vec%0d", i),
            {error_out, touched, piece_valid, loc_col, loc_row, rotation_out, curr_piece_out},
            {vecs[i].err, vecs[i].tch, vecs[i].pv, vecs[i].col, vecs[i].row, vecs[i].rot, vecs[i].typ});
    end
    check("vec_board", board_out, 32'h8000_0000);
    wait_idle("vec_clear_cycles", 8);

    // Square piece moved to column 0 falls to row 6, locks on the 7th drop
    do_reset();
    do_cmd(SPAWN, 2'd3);
    check("t2_type", curr_piece_out, 2'd3);
    do_cmd(LEFT, 2'd0);
    repeat (6) do_cmd(DROP, 2'd0);
    check("t2_row6", {touched, loc_row}, {1'b0, 3'd6});
    do_cmd(DROP, 2'd0);
    check("t2_lock", {touched, error_out, piece_valid}, {1'b1, 1'b0, 1'b0});
    check("t2_board", board_out, 32'h3300_0000);
    wait_idle("t2_clear_cycles", 8);

    // Single full row: row 6 content drops into row 7
    do_reset();
    do_cmd(SPAWN, 2'd1);
    do_cmd(LEFT, 2'd0);
    repeat (7) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    check("t4_lockA", touched, 1'b1);
    wait_idle("t4_clearA", 8);
    do_cmd(SPAWN, 2'd2);
    do_cmd(ROT, 2'd0);
    check("t4_rotB", {curr_piece_out, rotation_out, error_out}, {2'd2, 2'd1, 1'b0});
    repeat (6) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    check("t4_lockB", touched, 1'b1);
    check("t4_boardB", board_out, 32'h7600_0000);
    wait_idle("t4_clearB", 8);
    do_cmd(SPAWN, 2'd0);
    do_cmd(RIGHT, 2'd0);
    do_cmd(RIGHT, 2'd0);
    check("t4_colC", loc_col, 2'd3);
    repeat (7) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    check("t4_boardC", {touched, board_out}, {1'b1, 32'hF600_0000});
    wait_idle("t4_clear_cycles", 9);
    check("t4_board_after", board_out, 32'h6000_0000);
    check("t4_lines", lines_total, 8'd1);

    // Two full rows cleared in one pass
    do_reset();
    do_cmd(SPAWN, 2'd3);
    do_cmd(LEFT, 2'd0);
    repeat (6) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    wait_idle("t5_clearA", 8);
    do_cmd(SPAWN, 2'd1);
    do_cmd(LEFT, 2'd0);
    repeat (5) do_cmd(DROP, 2'd0);
    check("t5_rowB", loc_row, 3'd5);
    do_cmd(DROP, 2'd0);
    check("t5_boardB", {touched, board_out}, {1'b1, 32'h3330_0000});
    wait_idle("t5_clearB", 8);
    do_cmd(SPAWN, 2'd3);
    do_cmd(RIGHT, 2'd0);
    repeat (6) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    check("t5_boardC", {touched, board_out}, {1'b1, 32'hFF30_0000});
    wait_idle("t5_clear_cycles", 10);
    check("t5_board_after", board_out, 32'h3000_0000);
    check("t5_lines", lines_total, 8'd2);

    // Asynchronous reset while clearing
    do_cmd(SPAWN, 2'd0);
    repeat (6) do_cmd(DROP, 2'd0);
    do_cmd(DROP, 2'd0);
    check("t1_lock", touched, 1'b1);
    @(posedge clka);
    #3;
    check("t1_mid_clear_ready", ifc.cmd_ready, 1'b0);
    restart_n = 1'b0;
    #1;
    check("t1_async_reset", {board_out, lines_total, ifc.cmd_ready, piece_valid, game_over},
          {32'h0, 8'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clka);
    restart_n = 1'b1;
    @(posedge clka);
    #1;
    check("t1_idle_ready", ifc.cmd_ready, 1'b1);
    do_cmd(SPAWN, 2'd1);
    check("t1_spawn", {piece_valid, error_out, curr_piece_out}, {1'b1, 1'b0, 2'd1});

    // Stack squares up to row 0, then a blocked spawn ends the game
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_cmd(SPAWN, 2'd3);
      drop_to_lock($sformatf("t6_lock%0d", k));
      wait_idle($sformatf("t6_clear%0d", k), 8);
    end
    check("t6_board", board_out, 32'h6666_6666);
    do_cmd(SPAWN, 2'd0);
    check("t6_over", {error_out, game_over, ifc.cmd_ready, piece_valid, touched},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    do_cmd(DROP, 2'd0);
    check("t6_ignored", {error_out, game_over, ifc.cmd_ready, board_out},
          {1'b0, 1'b1, 1'b0, 32'h6666_6666});
    do_cmd(SPAWN, 2'd3);
    check("t6_ignored2", {error_out, game_over, ifc.cmd_ready, lines_total},
          {1'b0, 1'b1, 1'b0, 8'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
